hazard_control_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage core. Sequences stalls, bubbles, freezes and flushes of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Handles three hazard classes:
  - load-use hazards that the EX-stage forwarding unit cannot cover;
  - taken-branch flushes;
  - data-memory wait states.
- Also maintains stall/flush performance counters and a sticky memory-timeout flag.

---
 rtl/hazard_control_unit.sv | 164 ++++++++++++++++
 tb/tb_hazard_control_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller for the 5-stage core: load-use stalls, taken-branch flushes,
// data-memory wait freezes, plus stall/flush performance counters and a sticky timeout flag.
module hazard_control_unit #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT       = 255,
    parameter logic [4:0]  ZERO_REG          = 5'd0,
    parameter int unsigned CNT_W             = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       IFID_rm,
    input  logic [4:0]       IFID_rn,
    input  logic             IFID_UsesRm,
    input  logic             IFID_UsesRn,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_WriteRegister,
    input  logic             BranchTaken,
    input  logic             EXMEM_MemAccess,
    input  logic             DMemReady,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IDEX_Bubble,
    output logic             IDEX_Write,
    output logic             EXMEM_Write,
    output logic             MEMWB_Bubble,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic             MemTimeout
);

    // state      | meaning
    // RUN        | normal flow, load-use hazards detected here
    // LOAD_STALL | extra load-use bubbles still owed (stall_cnt_q remaining)
    // MEM_WAIT   | pipeline frozen on a data-memory access
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);

    state_t             state_q, state_d;
    logic [1:0]         stall_cnt_q, stall_cnt_d;
    logic [15:0]        wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;
    logic [CNT_W-1:0]   flush_count_q, flush_count_d;
    logic               mem_timeout_q, mem_timeout_d;

    logic mem_wait;
    logic load_use;

    assign mem_wait = EXMEM_MemAccess & ~DMemReady;
    assign load_use = IDEX_MemRead & (IDEX_WriteRegister != ZERO_REG) &
                      ((IFID_UsesRm & (IDEX_WriteRegister == IFID_rm)) |
                       (IFID_UsesRn & (IDEX_WriteRegister == IFID_rn)));

    always_comb begin
        PCWrite       = 1'b1;
        IFID_Write    = 1'b1;
        IDEX_Bubble   = 1'b0;
        IDEX_Write    = 1'b1;
        EXMEM_Write   = 1'b1;
        MEMWB_Bubble  = 1'b0;
        IFID_Flush    = 1'b0;
        IDEX_Flush    = 1'b0;
        EXMEM_Flush   = 1'b0;
        state_d       = state_q;
        stall_cnt_d   = stall_cnt_q;
        wait_cnt_d    = 16'd0;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        mem_timeout_d = mem_timeout_q;

        if (Reset) begin
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
            state_d     = RUN;
        end else if (mem_wait) begin
            PCWrite      = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Write  = 1'b0;
            MEMWB_Bubble = 1'b1;
            state_d      = MEM_WAIT;
            wait_cnt_d   = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
            if (32'(wait_cnt_d) >= MEM_TIMEOUT) begin
                mem_timeout_d = 1'b1;
            end
        end else if (BranchTaken) begin
            // the stalled consumer is on the wrong path, so any owed bubbles are dropped
            IFID_Flush    = 1'b1;
            IDEX_Flush    = 1'b1;
            EXMEM_Flush   = 1'b1;
            flush_count_d = flush_count_q + 1'b1;
            stall_cnt_d   = 2'd0;
            state_d       = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (load_use) begin
                        PCWrite     = 1'b0;
                        IFID_Write  = 1'b0;
                        IDEX_Bubble = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            stall_cnt_d = STALL_INIT;
                            state_d     = LOAD_STALL;
                        end
                    end
                end
                LOAD_STALL: begin
                    PCWrite     = 1'b0;
                    IFID_Write  = 1'b0;
                    IDEX_Bubble = 1'b1;
                    if (stall_cnt_q <= 2'd1) begin
                        stall_cnt_d = 2'd0;
                        state_d     = RUN;
                    end else begin
                        stall_cnt_d = stall_cnt_q - 2'd1;
                    end
                end
                MEM_WAIT: begin
                    // resume a load-use stall that the memory freeze interrupted
                    state_d = (stall_cnt_q != 2'd0) ? LOAD_STALL : RUN;
                end
                default: begin
                    state_d     = RUN;
                    stall_cnt_d = 2'd0;
                end
            endcase
        end

        if (!Reset && !PCWrite) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= RUN;
            stall_cnt_q   <= 2'd0;
            wait_cnt_q    <= 16'd0;
            stall_count_q <= '0;
            flush_count_q <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            stall_cnt_q   <= stall_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign StallCount = stall_count_q;
    assign FlushCount = flush_count_q;
    assign MemTimeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: three instances (1/2/3 load-stall cycles) share stimulus;
// the driver queues hand-computed expectations and a negedge monitor compares them.
module tb_hazard_control_unit;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [4:0] IFID_rm, IFID_rn, IDEX_WriteRegister;
    logic       IFID_UsesRm, IFID_UsesRn, IDEX_MemRead, BranchTaken, EXMEM_MemAccess, DMemReady;

    always #5 Clk = ~Clk;

    // flag order: PCWrite IFID_Write IDEX_Bubble IDEX_Write EXMEM_Write MEMWB_Bubble IFID_Flush IDEX_Flush EXMEM_Flush
    localparam logic [8:0] DEF = 9'b110110000;
    localparam logic [8:0] LU  = 9'b001110000;
    localparam logic [8:0] FRZ = 9'b000001000;
    localparam logic [8:0] BR  = 9'b110110111;
    localparam logic [8:0] RST = 9'b110110111;
    localparam logic [41:0] M_ALL   = {42{1'b1}};
    localparam logic [41:0] M_FLAGS = {9'h1FF, 33'd0};

    logic [41:0] obs0, obs1, obs2;

    typedef struct {
        string       name;
        int          inst;
        logic [41:0] exp;
        logic [41:0] mask;
    } sb_t;
    sb_t sb_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic        u_dut1_pw, u_dut1_ifw, u_dut1_idb, u_dut1_idw, u_dut1_exw, u_dut1_mwb, u_dut1_iff, u_dut1_idf, u_dut1_exf, u_dut1_to;
    logic [15:0] u_dut1_sc, u_dut1_fc;
    hazard_control_unit #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(4), .ZERO_REG(5'd0), .CNT_W(16)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .IFID_rm(IFID_rm), .IFID_rn(IFID_rn), .IFID_UsesRm(IFID_UsesRm),
        .IFID_UsesRn(IFID_UsesRn), .IDEX_MemRead(IDEX_MemRead), .IDEX_WriteRegister(IDEX_WriteRegister),
        .BranchTaken(BranchTaken), .EXMEM_MemAccess(EXMEM_MemAccess), .DMemReady(DMemReady),
        .PCWrite(u_dut1_pw), .IFID_Write(u_dut1_ifw), .IDEX_Bubble(u_dut1_idb), .IDEX_Write(u_dut1_idw),
        .EXMEM_Write(u_dut1_exw), .MEMWB_Bubble(u_dut1_mwb), .IFID_Flush(u_dut1_iff), .IDEX_Flush(u_dut1_idf),
        .EXMEM_Flush(u_dut1_exf), .StallCount(u_dut1_sc), .FlushCount(u_dut1_fc), .MemTimeout(u_dut1_to));
    assign obs0 = {u_dut1_pw, u_dut1_ifw, u_dut1_idb, u_dut1_idw, u_dut1_exw, u_dut1_mwb,
                   u_dut1_iff, u_dut1_idf, u_dut1_exf, u_dut1_sc, u_dut1_fc, u_dut1_to};

    logic        u_dut2_pw, u_dut2_ifw, u_dut2_idb, u_dut2_idw, u_dut2_exw, u_dut2_mwb, u_dut2_iff, u_dut2_idf, u_dut2_exf, u_dut2_to;
    logic [15:0] u_dut2_sc, u_dut2_fc;
    hazard_control_unit #(.LOAD_STALL_CYCLES(2), .MEM_TIMEOUT(255), .ZERO_REG(5'd0), .CNT_W(16)) u_dut2 (
        .Clk(Clk), .Reset(Reset), .IFID_rm(IFID_rm), .IFID_rn(IFID_rn), .IFID_UsesRm(IFID_UsesRm),
        .IFID_UsesRn(IFID_UsesRn), .IDEX_MemRead(IDEX_MemRead), .IDEX_WriteRegister(IDEX_WriteRegister),
        .BranchTaken(BranchTaken), .EXMEM_MemAccess(EXMEM_MemAccess), .DMemReady(DMemReady),
        .PCWrite(u_dut2_pw), .IFID_Write(u_dut2_ifw), .IDEX_Bubble(u_dut2_idb), .IDEX_Write(u_dut2_idw),
        .EXMEM_Write(u_dut2_exw), .MEMWB_Bubble(u_dut2_mwb), .IFID_Flush(u_dut2_iff), .IDEX_Flush(u_dut2_idf),
        .EXMEM_Flush(u_dut2_exf), .StallCount(u_dut2_sc), .FlushCount(u_dut2_fc), .MemTimeout(u_dut2_to));
    assign obs1 = {u_dut2_pw, u_dut2_ifw, u_dut2_idb, u_dut2_idw, u_dut2_exw, u_dut2_mwb,
                   u_dut2_iff, u_dut2_idf, u_dut2_exf, u_dut2_sc, u_dut2_fc, u_dut2_to};

    logic        u_dut3_pw, u_dut3_ifw, u_dut3_idb, u_dut3_idw, u_dut3_exw, u_dut3_mwb, u_dut3_iff, u_dut3_idf, u_dut3_exf, u_dut3_to;
    logic [15:0] u_dut3_sc, u_dut3_fc;
    hazard_control_unit #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(255), .ZERO_REG(5'd0), .CNT_W(16)) u_dut3 (
        .Clk(Clk), .Reset(Reset), .IFID_rm(IFID_rm), .IFID_rn(IFID_rn), .IFID_UsesRm(IFID_UsesRm),
        .IFID_UsesRn(IFID_UsesRn), .IDEX_MemRead(IDEX_MemRead), .IDEX_WriteRegister(IDEX_WriteRegister),
        .BranchTaken(BranchTaken), .EXMEM_MemAccess(EXMEM_MemAccess), .DMemReady(DMemReady),
        .PCWrite(u_dut3_pw), .IFID_Write(u_dut3_ifw), .IDEX_Bubble(u_dut3_idb), .IDEX_Write(u_dut3_idw),
        .EXMEM_Write(u_dut3_exw), .MEMWB_Bubble(u_dut3_mwb), .IFID_Flush(u_dut3_iff), .IDEX_Flush(u_dut3_idf),
        .EXMEM_Flush(u_dut3_exf), .StallCount(u_dut3_sc), .FlushCount(u_dut3_fc), .MemTimeout(u_dut3_to));
    assign obs2 = {u_dut3_pw, u_dut3_ifw, u_dut3_idb, u_dut3_idw, u_dut3_exw, u_dut3_mwb,
                   u_dut3_iff, u_dut3_idf, u_dut3_exf, u_dut3_sc, u_dut3_fc, u_dut3_to};

    function automatic logic [41:0] mk(logic [8:0] f, int s, int fl, logic t);
        return {f, 16'(s), 16'(fl), t};
    endfunction

    function automatic logic [41:0] pick(int inst);
        case (inst)
            0:       return obs0;
            1:       return obs1;
            default: return obs2;
        endcase
    endfunction

    always @(negedge Clk) begin
        while (sb_q.size() > 0) begin
            sb_t e;
            logic [41:0] act;
            e   = sb_q.pop_front();
            act = pick(e.inst);
            total_cnt++;
            if ((act & e.mask) === (e.exp & e.mask)) pass_cnt++;
            else $display("FAIL %s u%0d: got %h expected %h (mask %h)", e.name, e.inst + 1,
                          act & e.mask, e.exp & e.mask, e.mask);
        end
    end

    task automatic push(string name, int inst, logic [41:0] exp, logic [41:0] mask);
        sb_t e;
        e.name = name; e.inst = inst; e.exp = exp; e.mask = mask;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Reset = 1'b0; IFID_rm = 5'd0; IFID_rn = 5'd0; IFID_UsesRm = 1'b0; IFID_UsesRn = 1'b0;
        IDEX_MemRead = 1'b0; IDEX_WriteRegister = 5'd0; BranchTaken = 1'b0;
        EXMEM_MemAccess = 1'b0; DMemReady = 1'b1;
    endtask

    task automatic hazard();
        idle();
        IDEX_MemRead = 1'b1; IDEX_WriteRegister = 5'd5; IFID_rn = 5'd5; IFID_UsesRn = 1'b1;
    endtask

    // one cycle: expected flags/stall count per instance, shared flush count, timeout of u_dut1
    task automatic cyc(string name, logic [8:0] f0, int s0, logic [8:0] f1, int s1,
                       logic [8:0] f2, int s2, int fl, logic t0);
        push(name, 0, mk(f0, s0, fl, t0), M_ALL);
        push(name, 1, mk(f1, s1, fl, 1'b0), M_ALL);
        push(name, 2, mk(f2, s2, fl, 1'b0), M_ALL);
        tick();
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            idle();
            Reset = 1'b1;
            for (int k = 0; k < 3; k++) push("reset_outputs", k, mk(RST, 0, 0, 1'b0), M_FLAGS);
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        Reset = 1'b1;
        tick();
        do_reset();
        cyc("post_reset", DEF, 0, DEF, 0, DEF, 0, 0, 1'b0);

        hazard();
        cyc("lu_rn_c1", LU, 0, LU, 0, LU, 0, 0, 1'b0);
        idle();
        cyc("lu_rn_c2", DEF, 1, LU, 1, LU, 1, 0, 1'b0);
        cyc("lu_rn_c3", DEF, 1, DEF, 2, LU, 2, 0, 1'b0);
        cyc("lu_rn_c4", DEF, 1, DEF, 2, DEF, 3, 0, 1'b0);

        idle();
        IDEX_MemRead = 1'b1; IDEX_WriteRegister = 5'd0; IFID_rm = 5'd0; IFID_UsesRm = 1'b1; IFID_UsesRn = 1'b1;
        cyc("lu_zero_reg", DEF, 1, DEF, 2, DEF, 3, 0, 1'b0);
        idle();
        IDEX_MemRead = 1'b1; IDEX_WriteRegister = 5'd7; IFID_rn = 5'd7; IFID_rm = 5'd3; IFID_UsesRm = 1'b1;
        cyc("lu_unused_rn", DEF, 1, DEF, 2, DEF, 3, 0, 1'b0);
        idle();
        IDEX_MemRead = 1'b1; IDEX_WriteRegister = 5'd9; IFID_rm = 5'd9; IFID_UsesRm = 1'b1;
        cyc("lu_rm_c1", LU, 1, LU, 2, LU, 3, 0, 1'b0);
        idle();
        cyc("lu_rm_c2", DEF, 2, LU, 3, LU, 4, 0, 1'b0);
        cyc("lu_rm_c3", DEF, 2, DEF, 4, LU, 5, 0, 1'b0);
        cyc("lu_rm_c4", DEF, 2, DEF, 4, DEF, 6, 0, 1'b0);

        do_reset();
        hazard();
        BranchTaken = 1'b1;
        cyc("br_over_lu", BR, 0, BR, 0, BR, 0, 0, 1'b0);
        idle();
        cyc("br_after", DEF, 0, DEF, 0, DEF, 0, 1, 1'b0);
        hazard();
        cyc("br_abort_c1", LU, 0, LU, 0, LU, 0, 1, 1'b0);
        idle();
        BranchTaken = 1'b1;
        cyc("br_abort_c2", BR, 1, BR, 1, BR, 1, 1, 1'b0);
        idle();
        cyc("br_abort_c3", DEF, 1, DEF, 1, DEF, 1, 2, 1'b0);
        cyc("br_abort_c4", DEF, 1, DEF, 1, DEF, 1, 2, 1'b0);

        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle();
            EXMEM_MemAccess = 1'b1; DMemReady = 1'b0;
            cyc("mem_freeze", FRZ, i, FRZ, i, FRZ, i, 0, 1'b0);
        end
        idle();
        EXMEM_MemAccess = 1'b1;
        cyc("mem_release", DEF, 3, DEF, 3, DEF, 3, 0, 1'b0);
        idle();
        cyc("mem_after", DEF, 3, DEF, 3, DEF, 3, 0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            idle();
            EXMEM_MemAccess = 1'b1; DMemReady = 1'b0;
            cyc("timeout_wait", FRZ, 3 + i, FRZ, 3 + i, FRZ, 3 + i, 0, (i >= 4));
        end
        idle();
        EXMEM_MemAccess = 1'b1;
        cyc("timeout_release", DEF, 9, DEF, 9, DEF, 9, 0, 1'b1);
        idle();
        cyc("timeout_sticky", DEF, 9, DEF, 9, DEF, 9, 0, 1'b1);

        do_reset();
        cyc("timeout_cleared", DEF, 0, DEF, 0, DEF, 0, 0, 1'b0);
        hazard();
        cyc("lu_mem_c1", LU, 0, LU, 0, LU, 0, 0, 1'b0);
        idle();
        EXMEM_MemAccess = 1'b1; DMemReady = 1'b0;
        cyc("lu_mem_c2", FRZ, 1, FRZ, 1, FRZ, 1, 0, 1'b0);
        idle();
        EXMEM_MemAccess = 1'b1;
        cyc("lu_mem_c3", DEF, 2, DEF, 2, DEF, 2, 0, 1'b0);
        idle();
        cyc("lu_mem_c4", DEF, 2, LU, 2, LU, 2, 0, 1'b0);
        cyc("lu_mem_c5", DEF, 2, DEF, 3, LU, 3, 0, 1'b0);
        cyc("lu_mem_c6", DEF, 2, DEF, 3, DEF, 4, 0, 1'b0);

        hazard();
        cyc("rst_in_stall_c1", LU, 2, LU, 3, LU, 4, 0, 1'b0);
        idle();
        Reset = 1'b1;
        for (int k = 0; k < 3; k++) push("rst_in_stall_rst", k, mk(RST, 0, 0, 1'b0), M_FLAGS);
        tick();
        idle();
        cyc("rst_in_stall_c2", DEF, 0, DEF, 0, DEF, 0, 0, 1'b0);
        cyc("rst_in_stall_c3", DEF, 0, DEF, 0, DEF, 0, 0, 1'b0);

        tick();
        total_cnt++;
        if (sb_q.size() == 0) pass_cnt++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
